debug_dm_controller: RTL

//  Debug-module register file and sequencer between the JTAG-side DMI port and the CPU debug port.

---
 rtl/debug_dm_controller.sv | 276 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/debug_dm_controller.sv
// Debug module: DMI-facing register file plus halt/resume/reset and
// abstract memory-access sequencing towards the CPU debug port.
module debug_dm_controller #(
    parameter int NUM_PROGBUF      = 4,
    parameter int ABSTRACT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  dmi_address,
    input  logic [31:0] dmi_jtag_data,
    input  logic        dmi_new_request,
    input  logic        dmi_rnw,
    output logic        dmi_handled,
    output logic [1:0]  dmi_response,
    output logic [31:0] dmi_data,
    output logic        cpu_halt,
    output logic        cpu_resume,
    output logic        cpu_reset,
    input  logic        cpu_halt_ack,
    input  logic        cpu_resume_ack,
    input  logic        cpu_reset_ack,
    input  logic        cpu_running,
    output logic        cpu_rnw,
    output logic        cpu_rnw_new_request,
    output logic [31:0] cpu_read_write_addr,
    output logic [31:0] cpu_write_data,
    input  logic        cpu_rnw_ack,
    input  logic [31:0] cpu_read_data,
    input  logic [3:0]  cpu_program_buffer_addr,
    output logic [31:0] cpu_program_buffer_data
);

    localparam int PB_W = (NUM_PROGBUF > 1) ? $clog2(NUM_PROGBUF) : 1;
    localparam logic [15:0] TMO_LAST = 16'(ABSTRACT_TIMEOUT - 1);

    localparam logic [6:0] ADDR_DATA0  = 7'h04;
    localparam logic [6:0] ADDR_DATA1  = 7'h05;
    localparam logic [6:0] ADDR_DMCTL  = 7'h10;
    localparam logic [6:0] ADDR_DMSTAT = 7'h11;
    localparam logic [6:0] ADDR_ABSCS  = 7'h16;
    localparam logic [6:0] ADDR_CMD    = 7'h17;
    localparam logic [6:0] ADDR_PB     = 7'h20;

    localparam logic [1:0] RESP_OK   = 2'd0;
    localparam logic [1:0] RESP_FAIL = 2'd2;
    localparam logic [1:0] RESP_BUSY = 2'd3;

    typedef enum logic [1:0] {
        A_IDLE,
        A_REQ,
        A_WAIT
    } abs_state_t;

    abs_state_t  abs_state;
    logic        dmactive;
    logic        ndmreset;
    logic        havereset;
    logic        allresumeack;
    logic [2:0]  cmderr;
    logic [31:0] data0;
    logic [31:0] data1;
    logic [31:0] command;
    logic [31:0] progbuf [NUM_PROGBUF];
    logic        cmd_write;
    logic        cmd_postinc;
    logic [15:0] tmo_cnt;

    logic            req;
    logic            busy;
    logic            wr;
    logic            hit_data0;
    logic            hit_data1;
    logic            hit_dmctl;
    logic            hit_dmstat;
    logic            hit_abscs;
    logic            hit_cmd;
    logic            hit_pb;
    logic            mapped;
    logic            wr_blocked;
    logic            wr_ok;
    logic            dmctl_wr;
    logic            clear_all;
    logic [6:0]      pb_off;
    logic [PB_W-1:0] pb_sel;
    logic [PB_W-1:0] cpu_pb_sel;
    logic [31:0]     rd_data;
    logic [1:0]      resp;

    // A request landing in the handled cycle is not sampled.
    assign req  = dmi_new_request && !dmi_handled;
    assign busy = (abs_state != A_IDLE);
    assign wr   = req && !dmi_rnw;

    assign pb_off     = dmi_address - ADDR_PB;
    assign pb_sel     = pb_off[PB_W-1:0];
    assign hit_data0  = (dmi_address == ADDR_DATA0);
    assign hit_data1  = (dmi_address == ADDR_DATA1);
    assign hit_dmctl  = (dmi_address == ADDR_DMCTL);
    assign hit_dmstat = (dmi_address == ADDR_DMSTAT);
    assign hit_abscs  = (dmi_address == ADDR_ABSCS);
    assign hit_cmd    = (dmi_address == ADDR_CMD);
    assign hit_pb     = (dmi_address >= ADDR_PB) &&
                        (32'(pb_off) < NUM_PROGBUF);

    assign mapped = hit_data0 || hit_data1 || hit_dmctl ||
                    hit_dmstat || hit_abscs || hit_cmd || hit_pb;

    assign wr_blocked = wr && busy &&
                        (hit_data0 || hit_data1 || hit_cmd || hit_pb);
    assign wr_ok      = wr && !wr_blocked;
    assign dmctl_wr   = wr && hit_dmctl;
    assign clear_all  = rst || !dmactive ||
                        (dmctl_wr && !dmi_jtag_data[0]);

    assign cpu_reset           = ndmreset;
    assign cpu_read_write_addr = data1;
    assign cpu_write_data      = data0;

    assign cpu_pb_sel = PB_W'(32'(cpu_program_buffer_addr) % NUM_PROGBUF);
    assign cpu_program_buffer_data = progbuf[cpu_pb_sel];

    always_comb begin
        rd_data = '0;
        unique case (1'b1)
            hit_data0:  rd_data = data0;
            hit_data1:  rd_data = data1;
            hit_dmctl:  rd_data = {cpu_halt, cpu_resume, 28'b0,
                                   ndmreset, dmactive};
            hit_dmstat: rd_data = {12'b0, havereset, 1'b0, allresumeack,
                                   5'b0, cpu_running, 1'b0, !cpu_running,
                                   9'b0};
            hit_abscs:  rd_data = {19'b0, busy, 1'b0, cmderr, 8'b0};
            hit_cmd:    rd_data = command;
            hit_pb:     rd_data = progbuf[pb_sel];
            default:    rd_data = '0;
        endcase
    end

    always_comb begin
        resp = RESP_OK;
        if (!mapped) begin
            resp = RESP_FAIL;
        end else if (wr_blocked) begin
            resp = RESP_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmi_handled  <= 1'b0;
            dmi_response <= RESP_OK;
            dmi_data     <= '0;
        end else begin
            dmi_handled  <= req;
            dmi_response <= req ? resp : RESP_OK;
            dmi_data     <= (req && dmi_rnw && mapped) ? rd_data : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmactive <= 1'b0;
        end else if (dmctl_wr) begin
            dmactive <= dmi_jtag_data[0];
        end
    end

    always_ff @(posedge clk) begin
        if (clear_all) begin
            abs_state           <= A_IDLE;
            ndmreset            <= 1'b0;
            havereset           <= 1'b0;
            allresumeack        <= 1'b0;
            cmderr              <= 3'd0;
            data0               <= '0;
            data1               <= '0;
            command             <= '0;
            cmd_write           <= 1'b0;
            cmd_postinc         <= 1'b0;
            tmo_cnt             <= '0;
            cpu_halt            <= 1'b0;
            cpu_resume          <= 1'b0;
            cpu_rnw             <= 1'b0;
            cpu_rnw_new_request <= 1'b0;
            for (int i = 0; i < NUM_PROGBUF; i++) begin
                progbuf[i] <= '0;
            end
        end else begin
            if (dmctl_wr) begin
                ndmreset <= dmi_jtag_data[1];
                if (dmi_jtag_data[31]) begin
                    cpu_halt <= 1'b1;
                end else if (dmi_jtag_data[30]) begin
                    cpu_resume   <= 1'b1;
                    allresumeack <= 1'b0;
                end
                if (dmi_jtag_data[28]) begin
                    havereset <= 1'b0;
                end
            end
            if (wr_ok && hit_data0) begin
                data0 <= dmi_jtag_data;
            end
            if (wr_ok && hit_data1) begin
                data1 <= dmi_jtag_data;
            end
            if (wr_ok && hit_pb) begin
                progbuf[pb_sel] <= dmi_jtag_data;
            end
            if (wr && hit_abscs) begin
                cmderr <= cmderr & ~dmi_jtag_data[10:8];
            end
            if (wr_blocked && cmderr == 3'd0) begin
                cmderr <= 3'd1;
            end

            // CPU-side events are applied last so they win over DMI writes.
            if (cpu_halt_ack) begin
                cpu_halt <= 1'b0;
            end
            if (cpu_resume_ack) begin
                cpu_resume   <= 1'b0;
                allresumeack <= 1'b1;
            end
            if (cpu_reset_ack) begin
                havereset <= 1'b1;
            end

            cpu_rnw_new_request <= 1'b0;
            unique case (abs_state)
                A_IDLE: begin
                    if (wr_ok && hit_cmd) begin
                        command <= dmi_jtag_data;
                        if (cmderr == 3'd0) begin
                            if (dmi_jtag_data[31:24] != 8'd2) begin
                                cmderr <= 3'd2;
                            end else if (cpu_running) begin
                                cmderr <= 3'd4;
                            end else begin
                                cmd_write           <= dmi_jtag_data[16];
                                cmd_postinc         <= dmi_jtag_data[19];
                                cpu_rnw             <= !dmi_jtag_data[16];
                                cpu_rnw_new_request <= 1'b1;
                                abs_state           <= A_REQ;
                            end
                        end
                    end
                end
                A_REQ: begin
                    tmo_cnt   <= '0;
                    abs_state <= A_WAIT;
                end
                A_WAIT: begin
                    if (cpu_rnw_ack) begin
                        if (!cmd_write) begin
                            data0 <= cpu_read_data;
                        end
                        if (cmd_postinc) begin
                            data1 <= data1 + 32'd4;
                        end
                        abs_state <= A_IDLE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        cmderr    <= 3'd3;
                        abs_state <= A_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                default: begin
                    abs_state <= A_IDLE;
                end
            endcase
        end
    end

endmodule
